// File: rtl/uart8_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart8_rx_fifo
//
// Receive-side byte buffer placed directly behind the 8-bit UART receiver,
// running on the receiver's oversample clock. Each byte is captured on the
// receiver's one-cycle done pulse into a first-word-fall-through FIFO. The
// head byte is offered to the consumer on a valid/ready stream. The block
// also keeps sticky overrun/framing flags, a saturating error counter and an
// almost-full level that can drive RTS-style flow control.
//
// Parameters
//   ADDR_WIDTH   FIFO depth is 2**ADDR_WIDTH (legal 1..8)
//   AFULL_LEVEL  almostFull asserts when count >= AFULL_LEVEL
//                (legal 1..2**ADDR_WIDTH)
//
// Ports
//   clk         in   sole clock (receiver oversample clock)
//   rstn        in   asynchronous active-low reset
//   clear       in   synchronous flush of the FIFO contents
//   rxData      in   [7:0] byte from the receiver
//   rxDone      in   one-cycle pulse, rxData valid in the same cycle
//   rxErr       in   one-cycle framing error pulse from the receiver
//   outData     out  [7:0] head byte, 8'h00 when empty
//   outValid    out  FIFO holds at least one byte
//   outReady    in   consumer takes the head when outValid && outReady
//   count       out  [ADDR_WIDTH:0] occupancy, 0..DEPTH
//   empty       out  count == 0
//   full        out  count == DEPTH
//   almostFull  out  count >= AFULL_LEVEL
//   overrun     out  sticky: a byte was dropped because the FIFO was full
//   frameErr    out  sticky: rxErr was seen
//   errCount    out  [7:0] saturating count of rxErr pulses
//   errClear    in   synchronous clear of overrun, frameErr and errCount
// ---------------------------------------------------------------------------
module uart8_rx_fifo #(
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 14
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic [7:0]            rxData,
    input  logic                  rxDone,
    input  logic                  rxErr,
    output logic [7:0]            outData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almostFull,
    output logic                  overrun,
    output logic                  frameErr,
    output logic [7:0]            errCount,
    input  logic                  errClear
);

    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam int                  PTR_W   = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = PTR_W'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_AFULL = PTR_W'(AFULL_LEVEL);
    localparam logic [7:0]          C_SAT   = 8'hFF;

    // Storage and pointers. Pointers carry one extra bit so that full and
    // empty are distinguishable while the address bits are equal.
    logic [7:0]          r_mem [DEPTH];
    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;

    // Sticky status and error counter.
    logic                r_overrun;
    logic                r_frame_err;
    logic [7:0]          r_err_count;

    // Combinational decode.
    logic [ADDR_WIDTH:0] w_count;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [7:0]          w_head;

    // -----------------------------------------------------------------------
    // Occupancy and status flags
    // -----------------------------------------------------------------------
    // Modulo subtraction of the wrapped pointers gives occupancy directly.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == C_DEPTH);

    // -----------------------------------------------------------------------
    // Push / pop / drop decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        w_pop  = 1'b0;
        w_push = 1'b0;
        w_drop = 1'b0;

        if (!clear) begin
            w_pop = !w_empty && outReady;
            if (rxDone) begin
                // A pop in the same cycle frees a slot, so a full FIFO can
                // still accept the incoming byte.
                if (!w_full || w_pop) begin
                    w_push = 1'b1;
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pointer update
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of ordering.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    // NOTE: the array has no reset; its contents are unobservable until
    // written because outData is forced to zero while the FIFO is empty.
    // Leaving it unreset lets it map onto plain flops or distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= rxData;
        end
    end

    // First-word-fall-through: the head is read combinationally.
    assign w_head = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

    // -----------------------------------------------------------------------
    // Sticky flags and saturating error counter
    // -----------------------------------------------------------------------
    // A set event in the same cycle as errClear wins over the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_count <= 8'h00;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (errClear) begin
                r_overrun <= 1'b0;
            end

            if (rxErr) begin
                r_frame_err <= 1'b1;
            end else if (errClear) begin
                r_frame_err <= 1'b0;
            end

            if (errClear) begin
                r_err_count <= rxErr ? 8'h01 : 8'h00;
            end else if (rxErr && (r_err_count != C_SAT)) begin
                r_err_count <= r_err_count + 8'h01;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign outData    = w_empty ? 8'h00 : w_head;
    assign outValid   = !w_empty;
    assign count      = w_count;
    assign empty      = w_empty;
    assign full       = w_full;
    assign almostFull = (w_count >= C_AFULL);
    assign overrun    = r_overrun;
    assign frameErr   = r_frame_err;
    assign errCount   = r_err_count;

endmodule

// File: doc/uart8_rx_fifo.md
# uart8_rx_fifo

Receive-side buffer sitting directly downstream of the 8-bit UART receiver, on the same oversample clock. It captures each received byte on the receiver's one-cycle `done` pulse into a first-word-fall-through FIFO, and presents the bytes on a valid/ready stream to the consumer (CPU bus bridge or protocol parser). It also keeps sticky overrun and framing-error flags, a saturating error counter and an almost-full level for RTS-style flow control.

## Interface
- `ADDR_WIDTH`, 4: FIFO depth is 2**ADDR_WIDTH; legal range 1..8.
- `AFULL_LEVEL`, 14: `almostFull` asserts when `count >= AFULL_LEVEL`; legal range 1..2**ADDR_WIDTH.

- `clk`  in  1  sole clock (receiver oversample clock).
- `rstn`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush of FIFO contents.
- `rxData`  in  8  byte from receiver `out`.
- `rxDone`  in  1  one-cycle pulse from receiver `done`; `rxData` is valid in the same cycle.
- `rxErr`  in  1  one-cycle pulse from receiver `err`.
- `outData`  out  8  head byte; 8'h00 when empty.
- `outValid`  out  1  FIFO non-empty.
- `outReady`  in  1  consumer accepts the head byte when `outValid && outReady`.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `empty`, `full`, `almostFull`  out  1 each  status flags.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `frameErr`  out  1  sticky: `rxErr` was seen.
- `errCount`  out  8  saturating count of `rxErr` pulses.
- `errClear`  in  1  synchronous clear of `overrun`, `frameErr` and `errCount`.

## Operation
- Storage: DEPTH x 8 register array. Write and read pointers are ADDR_WIDTH+1 bits and wrap naturally. `count = wrPtr - rdPtr` (modulo).
- `empty = (count == 0)`. `full = (count == DEPTH)`. `outValid = !empty`. `outData = empty ? 8'h00 : mem[rdPtr[ADDR_WIDTH-1:0]]`, combinational from the storage.
- Pop: `outValid && outReady` advances `rdPtr` by one.
- Push: `rxDone` writes `rxData` at `wrPtr` and advances it, provided the FIFO is not full or a pop happens in the same cycle.
- `rxDone` while full with no pop: the byte is discarded, the pointers are unchanged and `overrun` is set.
- Simultaneous push and pop: both take effect and `count` is unchanged. This applies when full and when holding one entry. When empty, a pop is impossible because `outValid` = 0.
- `clear`: both pointers go to 0 next cycle. It overrides any push or pop in the same cycle; the byte is dropped without setting `overrun`. Sticky flags and `errCount` are unaffected.
- `rxErr`: sets `frameErr` and increments `errCount`, saturating at 8'hFF. An `rxErr` on the same cycle as `rxDone` is counted and the byte is still pushed.
- `errClear`: zeros `overrun`, `frameErr` and `errCount` next cycle. A set event in the same cycle wins: the flag ends up 1 and `errCount` ends up 1.
- `outReady` asserted while `outValid` = 0 has no effect.

## Timing
- Reset (`rstn` low, asynchronous): pointers = 0, `count` = 0, `empty` = 1, `full` = 0, `almostFull` = 0, `outValid` = 0, `outData` = 8'h00, `overrun` = 0, `frameErr` = 0, `errCount` = 0. Storage contents are not reset. Reset release is synchronous to `clk`; the first push is legal on the first edge after release.
- Push latency: a byte pushed at edge N appears with `outValid` = 1 and correct `outData` after edge N (visible in cycle N+1). `count` and all flags update on the same edge.
- Pop: the head is consumed at the edge where `outValid && outReady`. The next byte is presented in the following cycle, with no bubble.
- Sustained throughput: one push and one pop per cycle. The receiver produces at most one byte per 160 clocks.
- Reset asserted mid-stream: all contents are lost and outputs return to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, then push 0x55, 0xA3, 0x0F with `outReady` = 0 → `count` = 3, `outData` = 0x55. Raise `outReady` → 0x55, 0xA3, 0x0F on consecutive cycles, then `empty` = 1 and `outData` = 0x00.
- ADDR_WIDTH = 4: push 16 bytes 0x00..0x0F → `full` = 1, `almostFull` asserted from `count` = 14. A 17th push of 0xEE → dropped, `overrun` = 1, and the head is still 0x00 after 16 pops.
- Full FIFO with push 0x77 and pop in the same cycle → `count` stays 16, 0x77 is read last. Repeat 40 cycles to exercise pointer wrap; all bytes are returned in order.
- 300 `rxErr` pulses → `errCount` = 0xFF (saturated), `frameErr` = 1. `errClear` coincident with an `rxErr` → `errCount` = 1, `frameErr` = 1.
- `clear` coincident with `rxDone`(0x99) on a FIFO holding 5 entries → `count` = 0, `overrun` unchanged, 0x99 is never output.
- Assert `rstn` low between clock edges with 3 entries stored → `outValid`, `count`, `errCount` and `overrun` drop to reset values before the next edge.
